// File: rtl/mure_pkg.sv
// Shared trace-encoder types and widths.
// Retirement-tap slot and trap records live here.
package mure_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_LEN  = 32;
  localparam int unsigned CAUSE_LEN = 5;

  typedef struct packed {
    logic [XLEN-1:0]     iaddr;
    logic [INST_LEN-1:0] instr;
    logic                compressed;
    logic                valid;
  } retire_slot_t;

  typedef struct packed {
    logic                 exception;
    logic                 interrupt;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [XLEN-1:0]      epc;
  } retire_trap_t;

endpackage

// File: rtl/retire_serializer_if.sv
// Retirement bundle ingress and single-beat egress signals.
// slave = serializer view, master = tap/consumer view.
interface retire_serializer_if #(
    parameter int unsigned RETIRED_INSTR = 2
);
    import mure_pkg::*;

    logic [RETIRED_INSTR-1:0]          valids_i;
    logic [RETIRED_INSTR*XLEN-1:0]     iaddr_i;
    logic [RETIRED_INSTR*INST_LEN-1:0] instr_i;
    logic [RETIRED_INSTR-1:0]          compressed_i;
    logic                              exception_i;
    logic                              interrupt_i;
    logic [CAUSE_LEN-1:0]              cause_i;
    logic [XLEN-1:0]                   tval_i;
    logic [XLEN-1:0]                   epc_i;
    logic                              bundle_ready_o;
    logic                              overflow_o;

    logic                              valid_o;
    logic                              ready_i;
    logic                              iretired_o;
    logic [XLEN-1:0]                   iaddr_o;
    logic [INST_LEN-1:0]               inst_data_o;
    logic                              compressed_o;
    logic                              exception_o;
    logic                              interrupt_o;
    logic [CAUSE_LEN-1:0]              cause_o;
    logic [XLEN-1:0]                   tval_o;
    logic                              last_o;

    modport slave (
        input  valids_i, iaddr_i, instr_i, compressed_i,
        input  exception_i, interrupt_i, cause_i, tval_i, epc_i,
        output bundle_ready_o, overflow_o,
        output valid_o, iretired_o, iaddr_o, inst_data_o,
        output compressed_o, exception_o, interrupt_o,
        output cause_o, tval_o, last_o,
        input  ready_i
    );

    modport master (
        output valids_i, iaddr_i, instr_i, compressed_i,
        output exception_i, interrupt_i, cause_i, tval_i, epc_i,
        input  bundle_ready_o, overflow_o,
        input  valid_o, iretired_o, iaddr_o, inst_data_o,
        input  compressed_o, exception_o, interrupt_o,
        input  cause_o, tval_o, last_o,
        output ready_i
    );

endinterface

// File: rtl/mure_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth.
// Storage is cleared on reset so the head reads zero.
module mure_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/retire_serializer.sv
// Buffers multi-retire bundles and replays them
// as a one-instruction-per-beat valid/ready stream.
module retire_serializer
    import mure_pkg::*;
#(
    parameter int unsigned RETIRED_INSTR = 2,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    retire_serializer_if.slave bus
);

    localparam int unsigned SLOT_W =
        (RETIRED_INSTR > 1) ? $clog2(RETIRED_INSTR) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        retire_trap_t                      trap;
        retire_slot_t [RETIRED_INSTR-1:0]  slot;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    entry_t             in_e;
    entry_t             head;
    logic [ENTRY_W-1:0] head_raw;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt;

    logic               present;
    logic               push;
    logic               pop;
    logic               accept;
    logic               bundle_ready;
    logic               overflow_q;

    logic [SLOT_W-1:0]  slot_q;
    logic [SLOT_W-1:0]  cur;
    logic               found;
    logic               higher;
    logic               valid;
    logic               last;
    logic               trap_on;

    always_comb begin
        in_e = '0;
        for (int k = 0; k < int'(RETIRED_INSTR); k++) begin
            in_e.slot[k].iaddr      = bus.iaddr_i[k*XLEN +: XLEN];
            in_e.slot[k].instr      = bus.instr_i[k*INST_LEN +: INST_LEN];
            in_e.slot[k].compressed = bus.compressed_i[k];
            in_e.slot[k].valid      = bus.valids_i[k];
        end
        in_e.trap.exception = bus.exception_i;
        in_e.trap.interrupt = bus.interrupt_i;
        in_e.trap.cause     = bus.cause_i;
        in_e.trap.tval      = bus.tval_i;
        in_e.trap.epc       = bus.epc_i;
    end

    // Readiness comes from the registered count only; a same-cycle
    // pop never makes room for that cycle's push.
    assign bundle_ready = (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign present      = (|bus.valids_i) || bus.exception_i;
    assign push         = present && !fifo_full;

    mure_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (in_e),
        .pop_i   (pop),
        .data_o  (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign head  = entry_t'(head_raw);
    assign valid = !fifo_empty;

    always_comb begin
        found  = 1'b0;
        higher = 1'b0;
        cur    = '0;
        for (int k = 0; k < int'(RETIRED_INSTR); k++) begin
            if (head.slot[k].valid && (k >= int'(slot_q))) begin
                if (!found) begin
                    found = 1'b1;
                    cur   = SLOT_W'(k);
                end else begin
                    higher = 1'b1;
                end
            end
        end
    end

    assign last    = !higher;
    assign trap_on = last && head.trap.exception;
    assign accept  = valid && bus.ready_i;
    assign pop     = accept && last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                slot_q <= last ? '0 : cur + SLOT_W'(1);
            end
            if (present && !bundle_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Beat fields are forced to zero while no beat is offered.
    always_comb begin
        bus.valid_o        = valid;
        bus.bundle_ready_o = bundle_ready;
        bus.overflow_o     = overflow_q;
        bus.iretired_o     = 1'b0;
        bus.iaddr_o        = '0;
        bus.inst_data_o    = '0;
        bus.compressed_o   = 1'b0;
        bus.exception_o    = 1'b0;
        bus.interrupt_o    = 1'b0;
        bus.cause_o        = '0;
        bus.tval_o         = '0;
        bus.last_o         = 1'b0;
        if (valid) begin
            bus.iretired_o = found;
            bus.last_o     = last;
            if (found) begin
                bus.iaddr_o      = head.slot[cur].iaddr;
                bus.inst_data_o  = head.slot[cur].instr;
                bus.compressed_o = head.slot[cur].compressed;
            end else begin
                bus.iaddr_o = head.trap.epc;
            end
            if (trap_on) begin
                bus.exception_o = 1'b1;
                bus.interrupt_o = head.trap.interrupt;
                bus.cause_o     = head.trap.cause;
                bus.tval_o      = head.trap.tval;
            end
        end
    end

endmodule

// File: tb/tb_retire_serializer.sv
// Directed and random bench for retire_serializer
// against a bundle-queue reference model.
module tb_retire_serializer;
    import mure_pkg::*;

    localparam int unsigned RI    = 2;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic                 iret;
        logic [XLEN-1:0]      iaddr;
        logic [INST_LEN-1:0]  inst;
        logic                 comp;
        logic                 exc;
        logic                 irq;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic                 last;
    } beat_t;

    typedef struct {
        logic [1:0]           v;
        logic [XLEN-1:0]      pc [2];
        logic [INST_LEN-1:0]  ins [2];
        logic [1:0]           c;
        logic                 exc;
        logic                 irq;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [XLEN-1:0]      epc;
    } bun_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    retire_serializer_if #(.RETIRED_INSTR(RI)) bus ();

    retire_serializer #(
        .RETIRED_INSTR (RI),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int    n_chk  = 0;
    int    n_pass = 0;
    beat_t exp_q [$];
    int    n_bund = 0;
    logic  m_ovf  = 1'b0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bun_t mk(input logic [1:0] v,
                                input logic [31:0] pc0,
                                input logic [31:0] pc1,
                                input logic exc,
                                input logic [4:0] cause,
                                input logic [31:0] tval,
                                input logic [31:0] epc);
        bun_t b;
        b.v      = v;
        b.pc[0]  = pc0;
        b.pc[1]  = pc1;
        b.ins[0] = pc0 ^ 32'h0000_0013;
        b.ins[1] = pc1 ^ 32'h0000_0093;
        b.c      = 2'b01;
        b.exc    = exc;
        b.irq    = 1'b0;
        b.cause  = cause;
        b.tval   = tval;
        b.epc    = epc;
        return b;
    endfunction

    function automatic bun_t rnd();
        bun_t b;
        b.v      = 2'($urandom_range(0, 3));
        b.pc[0]  = $urandom & 32'hFFFF_FFFC;
        b.pc[1]  = $urandom & 32'hFFFF_FFFC;
        b.ins[0] = $urandom;
        b.ins[1] = $urandom;
        b.c      = 2'($urandom_range(0, 3));
        b.exc    = ($urandom_range(0, 5) == 0);
        b.irq    = 1'($urandom_range(0, 1));
        b.cause  = 5'($urandom);
        b.tval   = $urandom;
        b.epc    = $urandom;
        return b;
    endfunction

    function automatic bun_t idle();
        return mk(2'b00, 0, 0, 1'b0, 0, 0, 0);
    endfunction

    // Expected beats: valid slots in order, trap on the final one,
    // or a lone trap beat when no slot retired.
    task automatic model_push(input bun_t b);
        beat_t bs [$];
        beat_t t;
        for (int k = 0; k < 2; k++) begin
            if (b.v[k]) begin
                t       = '0;
                t.iret  = 1'b1;
                t.iaddr = b.pc[k];
                t.inst  = b.ins[k];
                t.comp  = b.c[k];
                bs.push_back(t);
            end
        end
        if (bs.size() == 0) begin
            t       = '0;
            t.iaddr = b.epc;
            bs.push_back(t);
        end
        t      = bs.pop_back();
        t.last = 1'b1;
        if (b.exc) begin
            t.exc   = 1'b1;
            t.irq   = b.irq;
            t.cause = b.cause;
            t.tval  = b.tval;
        end
        bs.push_back(t);
        foreach (bs[i]) exp_q.push_back(bs[i]);
        n_bund++;
    endtask

    task automatic drive(input bun_t b, input logic rdy, input logic rst);
        rst_i            = rst;
        bus.valids_i     = b.v;
        bus.iaddr_i      = {b.pc[1], b.pc[0]};
        bus.instr_i      = {b.ins[1], b.ins[0]};
        bus.compressed_i = b.c;
        bus.exception_i  = b.exc;
        bus.interrupt_i  = b.irq;
        bus.cause_i      = b.cause;
        bus.tval_i       = b.tval;
        bus.epc_i        = b.epc;
        bus.ready_i      = rdy;
    endtask

    // Check outputs, apply this cycle's inputs, advance the model.
    task automatic step(input bun_t b, input logic rdy, input logic rst);
        beat_t got;
        beat_t t;
        logic  room;
        logic  pres;
        got = {bus.iretired_o, bus.iaddr_o, bus.inst_data_o,
               bus.compressed_o, bus.exception_o, bus.interrupt_o,
               bus.cause_o, bus.tval_o, bus.last_o};
        check("valid_o", 128'(bus.valid_o), 128'(n_bund != 0));
        check("bundle_ready_o", 128'(bus.bundle_ready_o),
              128'(n_bund < int'(DEPTH)));
        check("overflow_o", 128'(bus.overflow_o), 128'(m_ovf));
        if (n_bund != 0) check("beat", 128'(got), 128'(exp_q[0]));
        drive(b, rdy, rst);
        pres = (|b.v) || b.exc;
        room = (n_bund < int'(DEPTH));
        if (rst) begin
            exp_q.delete();
            n_bund = 0;
            m_ovf  = 1'b0;
        end else begin
            if (n_bund != 0 && rdy) begin
                t = exp_q.pop_front();
                if (t.last) n_bund--;
            end
            if (pres) begin
                if (room) model_push(b);
                else m_ovf = 1'b1;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        beat_t got;
        drive(idle(), 1'b0, 1'b1);
        repeat (2) @(negedge clk_i);

        step(idle(), 1'b1, 1'b0);
        got = {bus.iretired_o, bus.iaddr_o, bus.inst_data_o,
               bus.compressed_o, bus.exception_o, bus.interrupt_o,
               bus.cause_o, bus.tval_o, bus.last_o};
        check("reset_data", 128'(got), 128'(0));

        step(mk(2'b11, 32'h100, 32'h104, 0, 0, 0, 0), 1'b1, 1'b0);
        repeat (3) step(idle(), 1'b1, 1'b0);

        step(mk(2'b10, 32'h0, 32'h200, 0, 0, 0, 0), 1'b1, 1'b0);
        repeat (2) step(idle(), 1'b1, 1'b0);

        step(mk(2'b01, 32'h180, 32'h0, 1, 5'd2, 32'hDEAD, 32'h180),
             1'b1, 1'b0);
        step(mk(2'b00, 32'h0, 32'h0, 1, 5'd3, 32'hBEEF, 32'h300),
             1'b1, 1'b0);
        repeat (3) step(idle(), 1'b1, 1'b0);

        step(mk(2'b11, 32'h400, 32'h404, 0, 0, 0, 0), 1'b0, 1'b0);
        repeat (5) step(idle(), 1'b0, 1'b0);
        repeat (3) step(idle(), 1'b1, 1'b0);

        for (int i = 0; i < int'(DEPTH) + 1; i++)
            step(mk(2'b11, 32'h500 + 16*i, 32'h504 + 16*i, 0, 0, 0, 0),
                 1'b0, 1'b0);
        repeat (2) step(idle(), 1'b0, 1'b0);
        repeat (10) step(idle(), 1'b1, 1'b0);

        for (int i = 0; i < 3; i++)
            step(mk(2'b11, 32'h600 + 16*i, 32'h604 + 16*i, 0, 0, 0, 0),
                 1'b0, 1'b0);
        step(idle(), 1'b0, 1'b1);
        step(mk(2'b01, 32'h700, 32'h0, 0, 0, 0, 0), 1'b1, 1'b0);
        repeat (2) step(idle(), 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            step(rnd(), ($urandom_range(0, 9) < 7), (i == 200));
        repeat (20) step(idle(), 1'b1, 1'b0);
        check("drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
